// File: rtl/vgacon_tty_ctrl.sv
// vgacon_tty_ctrl
//   Write-side sequencer for the VGA console text buffer. Turns a host
//   character stream into buffer writes and keeps the cursor. Handles CR, LF,
//   BS, FF and column wrap. The one-row scroll (copy rows up, blank the
//   bottom row) is held off until vertical blanking so no torn frame shows.
//   Buffer cells are 9 bits: {color[1:0], ascii[6:0]}.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   ch_valid/ch_data/       host character offer (ascii + color);
//   ch_color/ch_ready       transfer on ch_valid & ch_ready
//   vblank                  high while the display is outside the active frame
//   buf_raddr/buf_rdata     combinational buffer read port (scroll copy source)
//   buf_we/buf_waddr/       registered buffer write port
//   buf_wdata
//   cur_row/cur_col         registered cursor position
//   busy                    high whenever the controller is not idle
module vgacon_tty_ctrl #(
  parameter int NUM_ROWS = 3,
  parameter int NUM_COLS = 10,
  parameter int ADDR_W   = $clog2(NUM_ROWS*NUM_COLS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ch_valid,
  input  logic [6:0]        ch_data,
  input  logic [1:0]        ch_color,
  output logic              ch_ready,
  input  logic              vblank,
  output logic [ADDR_W-1:0] buf_raddr,
  input  logic [8:0]        buf_rdata,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_waddr,
  output logic [8:0]        buf_wdata,
  output logic [1:0]        cur_row,
  output logic [3:0]        cur_col,
  output logic              busy
);

  localparam logic [8:0]        BLANK_CELL  = 9'h020;
  localparam logic [ADDR_W-1:0] LAST_CELL   = ADDR_W'(NUM_ROWS*NUM_COLS-1);
  localparam logic [ADDR_W-1:0] LAST_COPY   = ADDR_W'(NUM_COLS*(NUM_ROWS-1)-1);
  localparam logic [ADDR_W-1:0] LAST_BLANK  = ADDR_W'(NUM_COLS-1);
  localparam logic [ADDR_W-1:0] COLS_A      = ADDR_W'(NUM_COLS);
  localparam logic [ADDR_W-1:0] BOTTOM_BASE = ADDR_W'((NUM_ROWS-1)*NUM_COLS);
  localparam logic [3:0]        LAST_COL    = 4'(NUM_COLS-1);
  localparam logic [1:0]        LAST_ROW    = 2'(NUM_ROWS-1);

  localparam logic [6:0] C_BS = 7'h08;
  localparam logic [6:0] C_LF = 7'h0A;
  localparam logic [6:0] C_FF = 7'h0C;
  localparam logic [6:0] C_CR = 7'h0D;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_WRITE,
    S_SCROLL_WAIT,
    S_SCROLL_COPY,
    S_SCROLL_BLANK
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] idx_reg;
  logic [6:0]        ch_reg;
  logic [1:0]        color_reg;
  logic [ADDR_W-1:0] cur_addr;

  assign cur_addr = ADDR_W'(cur_row) * COLS_A + ADDR_W'(cur_col);

  assign ch_ready = (state_reg == S_IDLE);
  assign busy     = (state_reg != S_IDLE);

  // Copy source is one row below the write target; it always leads the
  // pending write, so the copy never reads a cell it has already overwritten.
  assign buf_raddr = (state_reg == S_SCROLL_COPY) ? (idx_reg + COLS_A) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_CLEAR;
      idx_reg   <= '0;
      cur_row   <= '0;
      cur_col   <= '0;
      buf_we    <= 1'b0;
      buf_waddr <= '0;
      buf_wdata <= '0;
      ch_reg    <= '0;
      color_reg <= '0;
    end else begin
      // Write strobe is a one-cycle pulse unless a state re-asserts it.
      buf_we <= 1'b0;
      case (state_reg)
        S_CLEAR: begin
          buf_we    <= 1'b1;
          buf_waddr <= idx_reg;
          buf_wdata <= BLANK_CELL;
          if (idx_reg == LAST_CELL) begin
            idx_reg   <= '0;
            cur_row   <= '0;
            cur_col   <= '0;
            state_reg <= S_IDLE;
          end else begin
            idx_reg <= idx_reg + ADDR_W'(1);
          end
        end

        S_IDLE: begin
          if (ch_valid) begin
            if (ch_data >= 7'h20 && ch_data <= 7'h7E) begin
              ch_reg    <= ch_data;
              color_reg <= ch_color;
              state_reg <= S_WRITE;
            end else begin
              case (ch_data)
                C_CR: cur_col <= '0;
                C_LF: begin
                  cur_col <= '0;
                  if (cur_row < LAST_ROW) cur_row <= cur_row + 2'd1;
                  else                    state_reg <= S_SCROLL_WAIT;
                end
                C_BS: begin
                  if (cur_col != 4'd0) cur_col <= cur_col - 4'd1;
                end
                C_FF: begin
                  idx_reg   <= '0;
                  state_reg <= S_CLEAR;
                end
                default: ;  // unsupported control codes are swallowed
              endcase
            end
          end
        end

        S_WRITE: begin
          buf_we    <= 1'b1;
          buf_waddr <= cur_addr;
          buf_wdata <= {color_reg, ch_reg};
          if (cur_col < LAST_COL) begin
            cur_col   <= cur_col + 4'd1;
            state_reg <= S_IDLE;
          end else begin
            cur_col <= '0;
            if (cur_row < LAST_ROW) begin
              cur_row   <= cur_row + 2'd1;
              state_reg <= S_IDLE;
            end else begin
              state_reg <= S_SCROLL_WAIT;
            end
          end
        end

        S_SCROLL_WAIT: begin
          if (vblank) begin
            idx_reg   <= '0;
            state_reg <= S_SCROLL_COPY;
          end
        end

        // Once started, copy and blank run to completion regardless of vblank.
        S_SCROLL_COPY: begin
          buf_we    <= 1'b1;
          buf_waddr <= idx_reg;
          buf_wdata <= buf_rdata;
          if (idx_reg == LAST_COPY) begin
            idx_reg   <= '0;
            state_reg <= S_SCROLL_BLANK;
          end else begin
            idx_reg <= idx_reg + ADDR_W'(1);
          end
        end

        S_SCROLL_BLANK: begin
          buf_we    <= 1'b1;
          buf_waddr <= BOTTOM_BASE + idx_reg;
          buf_wdata <= BLANK_CELL;
          if (idx_reg == LAST_BLANK) begin
            idx_reg   <= '0;
            cur_row   <= LAST_ROW;
            cur_col   <= '0;
            state_reg <= S_IDLE;
          end else begin
            idx_reg <= idx_reg + ADDR_W'(1);
          end
        end

        default: state_reg <= S_CLEAR;
      endcase
    end
  end

endmodule

// File: doc/vgacon_tty_ctrl.md
Name: vgacon_tty_ctrl

Overview:
- Terminal-style sequencer that owns the write side of the VGA console text buffer (9-bit cells: {color[1:0], ascii[6:0]}).
- Accepts a character stream from the host-register layer and turns it into buffer writes, maintaining the cursor.
- Handles CR, LF, BS, FF and column wrap, and schedules the one-row scroll (copy plus blank) inside the vertical blanking window so no torn frame is displayed.

Parameters:
- NUM_ROWS, 3, text rows in the buffer.
- NUM_COLS, 10, characters per row.
- ADDR_W, $clog2(NUM_ROWS*NUM_COLS) = 5, buffer address width.

Ports:
- clk  in  1  project clock (64 MHz).
- rst_n  in  1  reset; asynchronous, active-low.
- ch_valid  in  1  host offers a character.
- ch_data  in  7  ASCII code.
- ch_color  in  2  color index stored with a printable character.
- ch_ready  out  1  controller accepts ch_data this cycle.
- vblank  in  1  synchronous level; high while the display is outside the active frame.
- buf_raddr  out  ADDR_W  combinational buffer read address (scroll copy source).
- buf_rdata  in  9  buffer read data, combinational from buf_raddr.
- buf_we  out  1  registered buffer write strobe.
- buf_waddr  out  ADDR_W  registered write address.
- buf_wdata  out  9  registered write data.
- cur_row  out  2  cursor row, registered.
- cur_col  out  4  cursor column, registered.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (async): state=CLEAR, idx=0, cur_row=0, cur_col=0, buf_we=0, buf_waddr=0, buf_wdata=0, ch_ready=0, busy=1.
- Cell address = row*NUM_COLS + col. Arithmetic is unsigned and truncated to ADDR_W.
- Blank cell value is 9'h020 (color 0, space).
- States: CLEAR, IDLE, WRITE, SCROLL_WAIT, SCROLL_COPY, SCROLL_BLANK.
- ch_ready = (state==IDLE), combinational. A transfer occurs on a clock edge where ch_valid & ch_ready.

CLEAR:
- Each cycle, register buf_we=1, waddr=idx, wdata=9'h020; idx increments.
- After idx = NUM_ROWS*NUM_COLS-1: cursor set to (0,0), go to IDLE.
- First write appears 1 cycle after reset release; 30 writes occur.
- Entered from reset and from FF.

IDLE, on transfer, by ch_data:
- 0x20-0x7E: latch the character and color, go to WRITE.
- 0x0D CR: cur_col=0. Stay in IDLE; no write.
- 0x0A LF: cur_col=0. If cur_row<NUM_ROWS-1, cur_row+1 and stay in IDLE; else go to SCROLL_WAIT.
- 0x08 BS: if cur_col>0, cur_col-1; at column 0 nothing changes. No write.
- 0x0C FF: idx=0, go to CLEAR.
- All other codes: consumed, no effect.

WRITE (exactly 1 cycle):
- Register buf_we=1, waddr=cursor address, wdata={color, ch}.
- If cur_col<NUM_COLS-1: cur_col+1, go to IDLE.
- Else: cur_col=0. If cur_row<NUM_ROWS-1, cur_row+1 and go to IDLE; else go to SCROLL_WAIT.
- Sustained printable throughput is 1 character per 2 cycles.

SCROLL_WAIT:
- buf_we=0. Hold until vblank=1, then idx=0 and go to SCROLL_COPY.
- If vblank is already high on entry, the copy starts the next cycle.

SCROLL_COPY:
- buf_raddr = idx+NUM_COLS, combinational.
- At each edge, register buf_we=1, waddr=idx, wdata=buf_rdata; idx increments.
- After idx = NUM_COLS*(NUM_ROWS-1)-1 (20 copies): idx=0, go to SCROLL_BLANK.
- The read address always leads the pending write address, so there is no hazard.

SCROLL_BLANK:
- Write 9'h020 to (NUM_ROWS-1)*NUM_COLS+idx for idx 0..NUM_COLS-1.
- Then cursor = (NUM_ROWS-1, 0), go to IDLE.

Scroll rules:
- A started scroll (COPY/BLANK, 30 cycles total) runs to completion even if vblank drops. The vblank window is far longer than 30 cycles.
- buf_we is low in the cycle after the last CLEAR/COPY/BLANK write unless a new write is issued.
- buf_raddr = 0 outside SCROLL_COPY.

Reset mid-operation:
- Reset aborts immediately: buf_we drops asynchronously, and a full CLEAR restarts on release. Partial scroll contents are irrelevant because they are overwritten.

Test Plan:
- Reset release -> exactly 30 consecutive writes of 9'h020 to addresses 0..29, then ch_ready=1, cursor (0,0).
- Send 'A' color 2, then 'B' color 0 -> writes 9'h141@0 and 9'h042@1 on consecutive WRITE cycles; cursor (0,2); ch_ready low exactly 1 cycle per character.
- From (0,9), send 'Z' -> write @9, cursor (1,0). Then send CR, BS, LF -> cursor (1,0), then (1,0), then (2,0), with no writes.
- Fill row 2 to (2,9) with vblank=0 and send 'Q' -> write 'Q'@29, controller waits. busy=1 and ch_ready=0 for 100 cycles. Raise vblank -> 20 copies (addresses 0..19 receive the old contents of 10..29), then 10 blanks @20..29, then cursor (2,0).
- Send FF at cursor (1,4) -> 30 clear writes, cursor (0,0). Send 0x07 -> consumed, no write, cursor unchanged.
- Assert rst_n low at copy index 7 -> buf_we=0 immediately, cursor (0,0). On release, a full 30-write CLEAR occurs.
